// File: rtl/id_ctrl_stage.sv
// Decode-stage control unit with its own ID/EX control register.
// Decodes mode/opcode/S into EX control and sequences multi-cycle MULs with flush/freeze handling.
module id_ctrl_stage #(
   parameter int               CMD_W      = 4,
   parameter int               MUL_CYCLES = 3,
   parameter logic [CMD_W-1:0] MUL_CMD    = CMD_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [1:0]       mode,
   input  logic [3:0]       opcode,
   input  logic             s,
   input  logic             immediate_in,
   input  logic             is_mul,
   input  logic             freeze,
   input  logic             flush,
   output logic             stall_out,
   output logic             ex_valid,
   output logic [CMD_W-1:0] ex_cmd,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_wb_en,
   output logic             ex_imm,
   output logic             ex_branch,
   output logic             ex_status_we,
   output logic             ex_ignore_haz,
   output logic             ex_illegal
);

   localparam int               CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam bit               MULTI_MUL = (MUL_CYCLES > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [CMD_W-1:0] cmd;
      logic             mem_read;
      logic             mem_write;
      logic             wb_en;
      logic             imm;
      logic             branch;
      logic             status_we;
      logic             ignore_haz;
      logic             illegal;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ex_q, ex_d;
   logic             mul_hit;

   function automatic ctrl_t mul_ctrl(input logic sb, input logic ib);
      ctrl_t c;
      c           = '0;
      c.valid     = 1'b1;
      c.cmd       = MUL_CMD;
      c.wb_en     = 1'b1;
      c.status_we = sb;
      c.imm       = ib;
      return c;
   endfunction

   // Illegal encodings carry only valid+illegal so EX traps without side effects.
   function automatic ctrl_t illegal_ctrl();
      ctrl_t c;
      c         = '0;
      c.valid   = 1'b1;
      c.illegal = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t decode(input logic [1:0] m, input logic [3:0] op,
                                    input logic sb, input logic ib, input logic mul);
      ctrl_t c;
      c       = '0;
      c.valid = 1'b1;
      case (m)
         2'b00: begin
            if (mul) begin
               c = mul_ctrl(sb, ib);
            end else begin
               c.imm       = ib;
               c.status_we = sb;
               c.wb_en     = 1'b1;
               case (op)
                  4'b1101: begin c.cmd = CMD_W'(4'b0001); c.ignore_haz = 1'b1; end
                  4'b1111: begin c.cmd = CMD_W'(4'b1001); c.ignore_haz = 1'b1; end
                  4'b0100: c.cmd = CMD_W'(4'b0010);
                  4'b0101: c.cmd = CMD_W'(4'b0011);
                  4'b0010: c.cmd = CMD_W'(4'b0100);
                  4'b0110: c.cmd = CMD_W'(4'b0101);
                  4'b0000: c.cmd = CMD_W'(4'b0110);
                  4'b1100: c.cmd = CMD_W'(4'b0111);
                  4'b0001: c.cmd = CMD_W'(4'b1000);
                  4'b1010: begin c.cmd = CMD_W'(4'b1100); c.wb_en = 1'b0; end
                  4'b1000: begin c.cmd = CMD_W'(4'b1110); c.wb_en = 1'b0; end
                  default: c = illegal_ctrl();
               endcase
            end
         end
         2'b01: begin
            c.cmd       = CMD_W'(4'b0010);
            c.mem_read  = sb;
            c.mem_write = ~sb;
            c.wb_en     = sb;
            c.imm       = ib;
         end
         2'b10: begin
            c.cmd        = '0;
            c.branch     = 1'b1;
            c.ignore_haz = 1'b1;
            c.imm        = ib;
         end
         default: c = illegal_ctrl();
      endcase
      return c;
   endfunction

   assign mul_hit = (mode == 2'b00) && is_mul;

   // Front-end stall depends only on current state and ID inputs, so it tracks freeze naturally.
   always_comb begin
      stall_out = 1'b0;
      case (state_q)
         IDLE:    stall_out = MULTI_MUL && valid_in && mul_hit;
         BUSY:    stall_out = (cnt_q > CNT_ONE);
         default: stall_out = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ex_d    = ex_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         ex_d    = '0;
      end else if (!freeze) begin
         case (state_q)
            IDLE: begin
               if (!valid_in) begin
                  ex_d = '0;
               end else if (MULTI_MUL && mul_hit) begin
                  ex_d    = '0;
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end else begin
                  ex_d = decode(mode, opcode, s, immediate_in, is_mul);
               end
            end
            BUSY: begin
               // Upstream holds the MUL fields while stalled, so the last count issues from them.
               if (cnt_q > CNT_ONE) begin
                  ex_d  = '0;
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  ex_d    = mul_ctrl(s, immediate_in);
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               ex_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ex_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_cmd        = ex_q.cmd;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_wb_en      = ex_q.wb_en;
   assign ex_imm        = ex_q.imm;
   assign ex_branch     = ex_q.branch;
   assign ex_status_we  = ex_q.status_we;
   assign ex_ignore_haz = ex_q.ignore_haz;
   assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed steps plus random traffic against
// a table-driven reference model that counts MUL latency in unfrozen edges.
module tb_id_ctrl_stage;

   localparam int               CMD_W      = 4;
   localparam int               MUL_CYCLES = 3;
   localparam logic [CMD_W-1:0] MUL_CMD    = 4'b1011;
   localparam int               VW         = CMD_W + 9;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             valid_in = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [3:0]       opcode = 4'h0;
   logic             s = 1'b0;
   logic             immediate_in = 1'b0;
   logic             is_mul = 1'b0;
   logic             freeze = 1'b0;
   logic             flush = 1'b0;
   logic             stall_out;
   logic             ex_valid;
   logic [CMD_W-1:0] ex_cmd;
   logic             ex_mem_read, ex_mem_write, ex_wb_en, ex_imm;
   logic             ex_branch, ex_status_we, ex_ignore_haz, ex_illegal;

   always #5 clk = ~clk;

   id_ctrl_stage #(.CMD_W(CMD_W), .MUL_CYCLES(MUL_CYCLES), .MUL_CMD(MUL_CMD)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .opcode(opcode), .s(s),
      .immediate_in(immediate_in), .is_mul(is_mul), .freeze(freeze), .flush(flush),
      .stall_out(stall_out), .ex_valid(ex_valid), .ex_cmd(ex_cmd),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
      .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_status_we(ex_status_we),
      .ex_ignore_haz(ex_ignore_haz), .ex_illegal(ex_illegal)
   );

   logic [VW-1:0] obs_ex;
   assign obs_ex = {ex_valid, ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm,
                    ex_branch, ex_status_we, ex_ignore_haz, ex_illegal};

   int            n_checks = 0;
   int            n_fail   = 0;
   int            data_cmd[16];
   logic [VW-1:0] exp_ex   = '0;
   int            mul_age  = -1;   // unfrozen edges since the pending MUL was first presented
   bit            hold_in  = 1'b0;
   bit            nxt_hold;

   function automatic logic [VW-1:0] pack(input logic v, input logic [CMD_W-1:0] cmd,
      input logic rd, input logic wr, input logic wb, input logic im, input logic br,
      input logic st, input logic ig, input logic il);
      return {v, cmd, rd, wr, wb, im, br, st, ig, il};
   endfunction

   function automatic logic [VW-1:0] ref_ctrl();
      logic [VW-1:0] r;
      if (mode == 2'b00 && is_mul)
         r = pack(1, MUL_CMD, 0, 0, 1, immediate_in, 0, s, 0, 0);
      else if (mode == 2'b00 && data_cmd[opcode] < 0)
         r = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (mode == 2'b00)
         r = pack(1, CMD_W'(data_cmd[opcode]), 0, 0,
                  (opcode != 4'b1010 && opcode != 4'b1000), immediate_in, 0, s,
                  (opcode == 4'b1101 || opcode == 4'b1111), 0);
      else if (mode == 2'b01)
         r = pack(1, 4'b0010, s, !s, s, immediate_in, 0, 0, 0, 0);
      else if (mode == 2'b10)
         r = pack(1, 4'b0000, 0, 0, 0, immediate_in, 1, 0, 1, 0);
      else
         r = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      return r;
   endfunction

   function automatic bit exp_stall();
      if (mul_age >= 0) return (MUL_CYCLES - mul_age) > 1;
      return valid_in && mode == 2'b00 && is_mul && MUL_CYCLES > 1;
   endfunction

   task automatic model_edge();
      if (flush) begin
         exp_ex  = '0;
         mul_age = -1;
      end else if (freeze) begin
         exp_ex = exp_ex;
      end else if (mul_age >= 0) begin
         mul_age++;
         if (mul_age >= MUL_CYCLES) begin
            exp_ex  = ref_ctrl();
            mul_age = -1;
         end else begin
            exp_ex = '0;
         end
      end else if (!valid_in) begin
         exp_ex = '0;
      end else if (mode == 2'b00 && is_mul && MUL_CYCLES > 1) begin
         mul_age = 1;
         exp_ex  = '0;
      end else begin
         exp_ex = ref_ctrl();
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
      input logic sb, input logic ib, input logic mul, input logic frz, input logic fl);
      valid_in = v; mode = m; opcode = op; s = sb; immediate_in = ib;
      is_mul = mul; freeze = frz; flush = fl;
   endtask

   task automatic cycle(input string tag);
      #1;
      check({tag, "/stall"}, 32'(stall_out), 32'(exp_stall()));
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "/ex"}, 32'(obs_ex), 32'(exp_ex));
   endtask

   initial begin
      foreach (data_cmd[i]) data_cmd[i] = -1;
      data_cmd[4'hD] = 1;  data_cmd[4'hF] = 9;  data_cmd[4'h4] = 2;  data_cmd[4'h5] = 3;
      data_cmd[4'h2] = 4;  data_cmd[4'h6] = 5;  data_cmd[4'h0] = 6;  data_cmd[4'hC] = 7;
      data_cmd[4'h1] = 8;  data_cmd[4'hA] = 12; data_cmd[4'h8] = 14;

      // Reset held: outputs stay cleared whatever the ID inputs do.
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 0,
               1'($urandom), 1'($urandom));
         #1;
         check("rst/stall", 32'(stall_out), 32'(0));
         @(posedge clk);
         #1;
         check("rst/ex", 32'(obs_ex), 32'(0));
      end
      rst = 1'b1;
      exp_ex = '0;
      mul_age = -1;

      drive(1, 2'b00, 4'b0100, 1, 1, 0, 0, 0);
      cycle("add_s");
      check("add_s/cmd", 32'(ex_cmd), 32'(4'b0010));
      check("add_s/flags", 32'({ex_valid, ex_wb_en, ex_status_we, ex_imm}), 32'(4'b1111));

      drive(1, 2'b00, 4'b1010, 1, 0, 0, 0, 0);
      cycle("cmp");
      check("cmp/cmd_wb", 32'({ex_cmd, ex_wb_en, ex_status_we}), 32'(6'b1100_0_1));
      drive(1, 2'b01, 4'b0000, 1, 0, 0, 0, 0);
      cycle("ldr");
      check("ldr/cmd_rd", 32'({ex_cmd, ex_mem_read, ex_wb_en, ex_status_we}), 32'(7'b0010_1_1_0));

      // MUL: stall 1,1,0 with bubbles, then issues on the third edge.
      drive(1, 2'b00, 4'b0000, 0, 0, 1, 0, 0);
      cycle("mul_e1");
      check("mul_e1/valid", 32'(ex_valid), 32'(0));
      cycle("mul_e2");
      cycle("mul_e3");
      check("mul_e3/cmd", 32'({ex_valid, ex_cmd}), 32'({1'b1, 4'b1011}));
      drive(0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
      cycle("bubble");

      // Two frozen cycles inside BUSY stretch the MUL by two.
      drive(1, 2'b00, 4'b0011, 1, 1, 1, 0, 0);
      cycle("mfz_e1");
      freeze = 1'b1;
      cycle("mfz_f1");
      cycle("mfz_f2");
      freeze = 1'b0;
      cycle("mfz_e2");
      check("mfz_e2/valid", 32'(ex_valid), 32'(0));
      cycle("mfz_e3");
      check("mfz_e3/cmd", 32'({ex_valid, ex_cmd, ex_status_we}), 32'({1'b1, 4'b1011, 1'b1}));

      // Flush with cnt = 2 aborts the MUL.
      drive(1, 2'b00, 4'b0000, 0, 0, 1, 0, 0);
      cycle("mfl_e1");
      flush = 1'b1;
      cycle("mfl_flush");
      drive(0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
      cycle("mfl_after");
      check("mfl_after/stall", 32'(stall_out), 32'(0));

      // Flush and freeze together: flush wins.
      drive(1, 2'b00, 4'b1101, 0, 1, 0, 0, 0);
      cycle("mov");
      drive(1, 2'b00, 4'b0000, 0, 0, 1, 0, 0);
      cycle("mff_e1");
      freeze = 1'b1;
      flush = 1'b1;
      cycle("mff_both");
      check("mff_both/ex", 32'(obs_ex), 32'(0));
      drive(0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
      cycle("mff_after");

      drive(1, 2'b11, 4'b0100, 1, 1, 0, 0, 0);
      cycle("ill_mode");
      check("ill_mode/bits", 32'(obs_ex), 32'(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      drive(1, 2'b00, 4'b0111, 0, 0, 0, 0, 0);
      cycle("ill_op");
      check("ill_op/bits", 32'({ex_illegal, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch}),
            32'(6'b110000));

      // Asynchronous reset in the middle of a MUL.
      drive(1, 2'b00, 4'b0000, 0, 0, 1, 0, 0);
      cycle("rmul_e1");
      #2;
      rst = 1'b0;
      drive(0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
      #1;
      check("rmul/ex", 32'(obs_ex), 32'(0));
      check("rmul/stall", 32'(stall_out), 32'(0));
      exp_ex = '0;
      mul_age = -1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1, 2'b00, 4'b0100, 0, 0, 0, 0, 0);
      cycle("rmul_add");

      // Random traffic; ID fields stay put while the front end is stalled or frozen.
      for (int i = 0; i < 400; i++) begin
         if (!hold_in) begin
            valid_in     = ($urandom_range(0, 4) != 0);
            mode         = 2'($urandom);
            opcode       = 4'($urandom);
            s            = 1'($urandom);
            immediate_in = 1'($urandom);
            is_mul       = ($urandom_range(0, 3) == 0);
         end
         freeze = ($urandom_range(0, 6) == 0);
         flush  = ($urandom_range(0, 14) == 0);
         nxt_hold = !flush && (exp_stall() || freeze);
         cycle($sformatf("rnd%0d", i));
         hold_in = nxt_hold;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
